int_log_calc: RTL
=================

Name: int_log_calc

Overview:
- Iterative integer logarithm unit; the inverse operation of the calculator's power block.
- Given an unsigned value and a base, it returns exponent = floor(log_base(value)), an exact flag (base^exponent == value) and an error flag.
- Sits beside the power block in the calculator datapath and uses one shared start/busy/done handshake.
- Uses one 8x4 multiply per clock, with no combinational loop unrolling.

Parameters:
- W_VAL, 8, width of value operand and internal accumulator
- W_BASE, 4, width of base operand
- W_EXP, 4, width of exponent result (must hold max exponent W_VAL-1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- base  in  W_BASE  logarithm base, unsigned
- value  in  W_VAL  argument, unsigned
- exponent  out  W_EXP  floor(log_base(value)); 0 on error
- exact  out  1  1 when base^exponent == value
- error  out  1  1 when base<2 or value==0
- busy  out  1  high while computing
- done  out  1  one-cycle pulse when results become valid

Behaviour:
- Reset (rst=1 at a clk edge, any state including mid-run):
  - state→IDLE.
  - exponent=0, exact=0, error=0, busy=0, done=0.
  - Internal accumulator, exponent counter and latched operands are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches base→base_q and value→val_q.
  - If base_q<2 or val_q==0: next state DONE with error=1, exponent=0, exact=0. done is asserted the cycle after start.
  - Otherwise: acc=1, exp_cnt=0, error=0, next state RUN. busy goes high the cycle after start.
- RUN, each cycle:
  - prod = acc*base_q, computed at W_VAL+W_BASE (12) bits so it cannot overflow.
  - If prod <= val_q: acc<=prod[7:0], exp_cnt<=exp_cnt+1, stay in RUN.
  - Else: exponent<=exp_cnt, exact<=(acc==val_q), next state DONE.
- Latency: number of RUN cycles = floor_log+1. Worst case is base=2, value>=128: 8 RUN cycles.
- DONE:
  - done=1 for exactly one cycle, busy=0, then IDLE.
  - A start in the DONE cycle is accepted, with the same rules as IDLE; done still pulses only once.
- Result persistence: exponent/exact/error hold their values until the next accepted start or reset. They are not cleared when returning to IDLE.
- Operands are latched at accept. Changes on base/value while busy have no effect.
- start while busy=1 is ignored. It is not queued.
- Invariant: acc <= val_q at all times, so acc fits in W_VAL bits and exp_cnt never exceeds W_VAL-1.
- value=1 with valid base: first RUN cycle exits immediately, giving exponent=0, exact=1.
- busy and done are never high in the same cycle.

Test Plan:
- Basic exact case: base=2, value=8, start pulse.
  - busy high for 4 cycles, then done pulse.
  - exponent=3, exact=1, error=0.
- Non-exact case: base=3, value=100.
  - exponent=4 (81<=100<243), exact=0.
  - done 5 RUN cycles after accept.
- Error cases: base=1,value=5 / base=0,value=5 / base=7,value=0.
  - Each gives error=1, exponent=0, exact=0.
  - done asserted the cycle after start; busy never high.
- Boundaries:
  - base=15, value=255 → exponent=2, exact=0.
  - base=2, value=255 → exponent=7, exact=0, 8 RUN cycles.
  - base=9, value=1 → exponent=0, exact=1.
- Handshake:
  - Start base=2,value=200; change inputs and pulse start during busy → ignored, result exponent=7.
  - Start issued in the DONE cycle with base=5,value=125 → accepted, exponent=3, exact=1.
- Reset mid-run:
  - Assert rst on the 3rd RUN cycle of base=2,value=255.
  - Next cycle all outputs are 0 and state is IDLE.
  - A subsequent start with base=4,value=64 gives exponent=3, exact=1.

Source files
------------

// File: rtl/int_log_calc_if.sv
// int_log_calc_if
// ---------------
// Purpose: bundles the start/busy/done handshake, the operands and the
// results of the integer logarithm unit. This is the same handshake shape
// the neighbouring power block in the calculator datapath uses.
//
// Signals:
//   start     request pulse, sampled by the unit only while busy=0
//   base      logarithm base, unsigned (W_BASE bits)
//   value     logarithm argument, unsigned (W_VAL bits)
//   exponent  floor(log_base(value)), 0 on error (W_EXP bits)
//   exact     1 when base^exponent == value
//   error     1 when base<2 or value==0
//   busy      high while the unit is iterating
//   done      one-cycle pulse when the results become valid
//
// Modports:
//   master  drives start/base/value and reads the results (datapath side)
//   slave   the logarithm unit itself
interface int_log_calc_if #(
    parameter int W_VAL  = 8,
    parameter int W_BASE = 4,
    parameter int W_EXP  = 4
) ();
    logic              start;
    logic [W_BASE-1:0] base;
    logic [W_VAL-1:0]  value;
    logic [W_EXP-1:0]  exponent;
    logic              exact;
    logic              error;
    logic              busy;
    logic              done;

    modport master (
        output start, base, value,
        input  exponent, exact, error, busy, done
    );

    modport slave (
        input  start, base, value,
        output exponent, exact, error, busy, done
    );
endinterface

// File: rtl/int_log_calc.sv
// int_log_calc
// ------------
// Purpose: iterative integer logarithm. For an unsigned value and base it
// returns exponent = floor(log_base(value)), an exact flag
// (base^exponent == value) and an error flag (base<2 or value==0).
// Each RUN cycle performs one acc*base multiply. For a valid request the
// unit spends floor_log+1 cycles in RUN, then pulses done for one cycle.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous, active-high reset
//   bus   int_log_calc_if.slave: start/base/value in,
//         exponent/exact/error/busy/done out
module int_log_calc #(
    parameter int W_VAL  = 8,
    parameter int W_BASE = 4,
    parameter int W_EXP  = 4
) (
    input  logic           clk,
    input  logic           rst,
    int_log_calc_if.slave  bus
);
    localparam int W_PROD = W_VAL + W_BASE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [W_BASE-1:0] base_q;
    logic [W_VAL-1:0]  val_q;
    logic [W_VAL-1:0]  acc;
    logic [W_EXP-1:0]  exp_cnt;

    logic [W_EXP-1:0]  exponent_q;
    logic              exact_q;
    logic              error_q;

    logic [W_PROD-1:0] prod;
    logic              step_ok;
    logic              accept;
    logic              operand_bad;

    // A start is accepted in any state except RUN, including the DONE cycle.
    assign accept      = bus.start && (state != RUN);
    // The operand check looks at the live inputs, because the operands are
    // being latched on this same edge.
    assign operand_bad = (bus.base < W_BASE'(2)) || (bus.value == '0);

    // The product is kept at full width so that acc*base can never wrap.
    // acc stays <= val_q, so the truncated form fits back into acc.
    assign prod    = W_PROD'(acc) * W_PROD'(base_q);
    assign step_ok = (prod <= W_PROD'(val_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = operand_bad ? DONE : RUN;
                end
            end
            RUN: begin
                if (!step_ok) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_next = operand_bad ? DONE : RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The datapath registers are cleared only by reset or by a new accepted
    // start. The results therefore persist after the unit returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            val_q      <= '0;
            acc        <= '0;
            exp_cnt    <= '0;
            exponent_q <= '0;
            exact_q    <= 1'b0;
            error_q    <= 1'b0;
        end else if (accept) begin
            base_q     <= bus.base;
            val_q      <= bus.value;
            acc        <= W_VAL'(1);
            exp_cnt    <= '0;
            exponent_q <= '0;
            exact_q    <= 1'b0;
            error_q    <= operand_bad;
        end else if (state == RUN) begin
            if (step_ok) begin
                acc     <= prod[W_VAL-1:0];
                exp_cnt <= exp_cnt + W_EXP'(1);
            end else begin
                exponent_q <= exp_cnt;
                exact_q    <= (acc == val_q);
            end
        end
    end

    assign bus.exponent = exponent_q;
    assign bus.exact    = exact_q;
    assign bus.error    = error_q;
    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
endmodule
